// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_pkg
// Brief    : Shared types and constants for the I2C write sequencer family.
// Revision : 1.0
// ============================================================================
package i2c_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 7;
    localparam int unsigned DEF_DATA_WIDTH = 8;

    localparam logic WRITE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_ACK     = 3'd3,
        ST_STOP    = 3'd4,
        ST_STOP_HI = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/edge_strobe.sv
`default_nettype none
// ============================================================================
// Module   : edge_strobe
// Brief    : Registers a level and emits one-cycle rise/fall strobes.
// Revision : 1.0
// ============================================================================
module edge_strobe (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    output logic rise_o,
    output logic fall_o
);

    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level_i;
        end
    end

    assign rise_o = level_i & ~prev_q;
    assign fall_o = ~level_i & prev_q;

endmodule
`default_nettype wire

// File: rtl/i2c_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : i2c_write_sequencer
// Brief    : Frames an I2C single-byte write, paced by external ClockI2C edges.
// Revision : 1.0
// ============================================================================
module i2c_write_sequencer
    import i2c_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  Reset,
    input  logic                  Go,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] Data,
    input  logic                  ClockI2C,
    input  logic                  SDAIn,
    output logic                  BaudEnable,
    output logic                  SCL,
    output logic                  SDA,
    output logic                  Busy,
    output logic                  Done,
    output logic                  AckError
);

    // Frames are left-aligned so the MSB is always the bit on the wire.
    localparam int unsigned c_SHIFT_W =
        ((ADDR_WIDTH + 1) > DATA_WIDTH) ? (ADDR_WIDTH + 1) : DATA_WIDTH;
    localparam int unsigned c_CNT_W = $clog2(c_SHIFT_W);
    localparam logic [c_CNT_W-1:0] c_ADDR_LAST = c_CNT_W'(ADDR_WIDTH);
    localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DATA_WIDTH - 1);

    state_t                  state_q,  state_d;
    logic [c_SHIFT_W-1:0]    shift_q,  shift_d;
    logic [DATA_WIDTH-1:0]   data_q,   data_d;
    logic [c_CNT_W-1:0]      bitcnt_q, bitcnt_d;
    logic                    phase_q,  phase_d;
    logic                    ackbit_q, ackbit_d;
    logic                    ackerr_q, ackerr_d;
    logic                    scl_q,    scl_d;
    logic                    sda_q,    sda_d;
    logic                    baud_q,   baud_d;
    logic                    busy_q,   busy_d;
    logic                    done_q,   done_d;

    logic                    w_rise;
    logic                    w_fall;

    edge_strobe u_edge_strobe (
        .clk_i   (clock),
        .rst_i   (Reset),
        .level_i (ClockI2C),
        .rise_o  (w_rise),
        .fall_o  (w_fall)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        data_d   = data_q;
        bitcnt_d = bitcnt_q;
        phase_d  = phase_q;
        ackbit_d = ackbit_q;
        ackerr_d = ackerr_q;
        scl_d    = 1'b1;
        sda_d    = 1'b1;
        baud_d   = 1'b1;
        busy_d   = 1'b1;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                baud_d = 1'b0;
                busy_d = 1'b0;
                if (Go) begin
                    shift_d = '0;
                    shift_d[c_SHIFT_W-1 -: ADDR_WIDTH+1] = {Address, WRITE};
                    data_d   = Data;
                    ackerr_d = 1'b0;
                    phase_d  = 1'b0;
                    state_d  = ST_START;
                    baud_d   = 1'b1;
                    busy_d   = 1'b1;
                    sda_d    = 1'b0;
                end
            end

            ST_START: begin
                sda_d = 1'b0;
                if (w_fall) begin
                    state_d  = ST_SHIFT;
                    bitcnt_d = c_ADDR_LAST;
                    sda_d    = shift_q[c_SHIFT_W-1];
                    scl_d    = ClockI2C;
                end
            end

            ST_SHIFT: begin
                scl_d = ClockI2C;
                sda_d = shift_q[c_SHIFT_W-1];
                if (w_fall) begin
                    if (bitcnt_q == '0) begin
                        state_d = ST_ACK;
                        sda_d   = 1'b1;
                    end else begin
                        shift_d  = {shift_q[c_SHIFT_W-2:0], 1'b0};
                        bitcnt_d = bitcnt_q - c_CNT_W'(1);
                        sda_d    = shift_q[c_SHIFT_W-2];
                    end
                end
            end

            ST_ACK: begin
                scl_d = ClockI2C;
                if (w_rise) begin
                    ackbit_d = SDAIn;
                end
                if (w_fall) begin
                    if (ackbit_q) begin
                        ackerr_d = 1'b1;
                        state_d  = ST_STOP;
                        sda_d    = 1'b0;
                    end else if (!phase_q) begin
                        shift_d = '0;
                        shift_d[c_SHIFT_W-1 -: DATA_WIDTH] = data_q;
                        bitcnt_d = c_DATA_LAST;
                        phase_d  = 1'b1;
                        state_d  = ST_SHIFT;
                        sda_d    = data_q[DATA_WIDTH-1];
                    end else begin
                        state_d = ST_STOP;
                        sda_d   = 1'b0;
                    end
                end
            end

            ST_STOP: begin
                sda_d = 1'b0;
                scl_d = ClockI2C;
                if (w_rise) begin
                    state_d = ST_STOP_HI;
                    scl_d   = 1'b1;
                end
            end

            ST_STOP_HI: begin
                sda_d = 1'b0;
                // SDA rising while SCL is held high is the STOP condition.
                if (w_fall) begin
                    sda_d   = 1'b1;
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    baud_d  = 1'b0;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                baud_d  = 1'b0;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                baud_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            data_q   <= '0;
            bitcnt_q <= '0;
            phase_q  <= 1'b0;
            ackbit_q <= 1'b0;
            ackerr_q <= 1'b0;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
            baud_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            bitcnt_q <= bitcnt_d;
            phase_q  <= phase_d;
            ackbit_q <= ackbit_d;
            ackerr_q <= ackerr_d;
            scl_q    <= scl_d;
            sda_q    <= sda_d;
            baud_q   <= baud_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign BaudEnable = baud_q;
    assign SCL        = scl_q;
    assign SDA        = sda_q;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign AckError   = ackerr_q;

endmodule
`default_nettype wire
